// File: rtl/acc_pkg.sv
// Shared opcode encoding, default widths and the saturating clamp used by the
// TIS-100 accumulator datapath.
package acc_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_MOV = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_NEG = 4'd4,
        OP_SAV = 4'd5,
        OP_SWP = 4'd6,
        OP_POP = 4'd7,
        OP_CLR = 4'd8
    } acc_op_t;

    localparam int ACC_WIDTH = 11;
    localparam int ACC_LIMIT = 999;

    // Values are carried as 32-bit signed so one function serves any WIDTH.
    function automatic int sat_clamp(input int value, input int limit);
        if (value > limit) begin
            return limit;
        end
        if (value < -limit) begin
            return -limit;
        end
        return value;
    endfunction

endpackage

// File: rtl/bak_stack.sv
// Shift-register LIFO backing the BAK store; entry 0 is the top.
// A push onto a full stack drops the bottom entry; a swap on an empty stack acts as a push.
module bak_stack #(
    parameter int  WIDTH = 11,
    parameter int  DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    swap,
    input  logic                    clr,
    input  logic signed [WIDTH-1:0] swap_in,
    output logic signed [WIDTH-1:0] top,
    output logic [CW-1:0]           count
);

    logic signed [WIDTH-1:0] mem [DEPTH];
    logic                    empty;
    logic                    full;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign top   = empty ? '0 : mem[0];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push || (swap && empty)) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                mem[i] <= mem[i-1];
            end
            mem[0] <= swap_in;
            if (!full) begin
                count <= count + 1'b1;
            end
        end else if (swap) begin
            mem[0] <= swap_in;
        end else if (pop && !empty) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem[i] <= mem[i+1];
            end
            mem[DEPTH-1] <= '0;
            count        <= count - 1'b1;
        end
    end

endmodule

// File: rtl/acc_bank.sv
// TIS-100 ACC register with a BAK stack: one opcode per cycle, results
// saturated to +/-LIMIT, sat pulse and sticky err flags.
module acc_bank
    import acc_pkg::*;
#(
    parameter int  WIDTH = ACC_WIDTH,
    parameter int  LIMIT = ACC_LIMIT,
    parameter int  DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    op_valid,
    input  acc_op_t                 op,
    input  logic signed [WIDTH-1:0] operand,
    output logic signed [WIDTH-1:0] acc_out,
    output logic signed [WIDTH-1:0] bak_top,
    output logic [CW-1:0]           depth_cnt,
    output logic                    zero,
    output logic                    neg,
    output logic                    sat,
    output logic                    err
);

    logic signed [WIDTH-1:0] acc_p0;
    logic                    sat_p0;
    logic                    err_p0;

    logic signed [WIDTH-1:0] acc_nxt;
    logic                    sat_nxt;
    logic                    err_nxt;
    logic                    stk_push;
    logic                    stk_pop;
    logic                    stk_swap;
    logic                    stk_clr;
    logic signed [WIDTH-1:0] stk_top;
    logic [CW-1:0]           stk_cnt;

    int                      opd_i;
    int                      opc_i;
    int                      add_i;
    int                      sub_i;
    logic signed [WIDTH-1:0] opc_w;
    logic signed [WIDTH:0]   acc_x;
    logic signed [WIDTH:0]   opc_x;
    logic signed [WIDTH:0]   add_w;
    logic signed [WIDTH:0]   sub_w;
    logic                    opd_sat;

    bak_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .CLK     (CLK),
        .nRST    (nRST),
        .push    (stk_push),
        .pop     (stk_pop),
        .swap    (stk_swap),
        .clr     (stk_clr),
        .swap_in (acc_p0),
        .top     (stk_top),
        .count   (stk_cnt)
    );

    // Operand is clamped first; the sum of two in-range values fits WIDTH+1 bits.
    always_comb begin
        opd_i   = int'(operand);
        opc_i   = sat_clamp(opd_i, LIMIT);
        opd_sat = (opc_i != opd_i);
        opc_w   = WIDTH'(opc_i);
        acc_x   = {acc_p0[WIDTH-1], acc_p0};
        opc_x   = {opc_w[WIDTH-1], opc_w};
        add_w   = acc_x + opc_x;
        sub_w   = acc_x - opc_x;
        add_i   = sat_clamp(int'(add_w), LIMIT);
        sub_i   = sat_clamp(int'(sub_w), LIMIT);
    end

    always_comb begin
        acc_nxt  = acc_p0;
        sat_nxt  = 1'b0;
        err_nxt  = err_p0;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_swap = 1'b0;
        stk_clr  = 1'b0;
        if (op_valid) begin
            case (op)
                OP_NOP: ;
                OP_MOV: begin
                    acc_nxt = opc_w;
                    sat_nxt = opd_sat;
                end
                OP_ADD: begin
                    acc_nxt = WIDTH'(add_i);
                    sat_nxt = opd_sat || (add_i != int'(add_w));
                end
                OP_SUB: begin
                    acc_nxt = WIDTH'(sub_i);
                    sat_nxt = opd_sat || (sub_i != int'(sub_w));
                end
                OP_NEG: acc_nxt = -acc_p0;
                OP_SAV: stk_push = 1'b1;
                OP_SWP: begin
                    // stk_top reads 0 when empty, which is the required ACC value.
                    stk_swap = 1'b1;
                    acc_nxt  = stk_top;
                end
                OP_POP: begin
                    if (stk_cnt == '0) begin
                        acc_nxt = '0;
                        err_nxt = 1'b1;
                    end else begin
                        stk_pop = 1'b1;
                        acc_nxt = stk_top;
                    end
                end
                OP_CLR: begin
                    stk_clr = 1'b1;
                    acc_nxt = '0;
                    err_nxt = 1'b0;
                end
                default: err_nxt = 1'b1;
            endcase
        end
    end

    // Register stage
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            acc_p0 <= '0;
            sat_p0 <= 1'b0;
            err_p0 <= 1'b0;
        end else begin
            acc_p0 <= acc_nxt;
            sat_p0 <= sat_nxt;
            err_p0 <= err_nxt;
        end
    end

    assign acc_out   = acc_p0;
    assign bak_top   = stk_top;
    assign depth_cnt = stk_cnt;
    assign zero      = (acc_p0 == '0);
    assign neg       = acc_p0[WIDTH-1];
    assign sat       = sat_p0;
    assign err       = err_p0;

endmodule
